branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 122 ++++++++++++
 tb/tb_branch_predictor.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Fetch looks up by PCF, Execute updates by PCE; the Fetch prediction is piped
// through Decode and Execute so the hazard unit can detect mispredictions.
module branch_predictor #(
  parameter int unsigned IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        FlushE,
  input  logic        BranchE,
  input  logic        BranchTaken,
  input  logic [31:0] PCE,
  input  logic [31:0] BranchTargetE,
  output logic        PredictTakenF,
  output logic [31:0] PredictTargetF,
  output logic        PredictTaken,
  output logic        Mispredict
);

  localparam int unsigned Entries = 1 << IDX_BITS;
  localparam int unsigned TagW    = 30 - IDX_BITS;

  // Table state
  logic [Entries-1:0] valid_q, valid_d;
  logic [TagW-1:0]    tag_q [Entries];
  logic [TagW-1:0]    tag_d [Entries];
  logic [1:0]         ctr_q [Entries];
  logic [1:0]         ctr_d [Entries];
  logic [31:0]        tgt_q [Entries];
  logic [31:0]        tgt_d [Entries];

  // Prediction pipeline: Decode- and Execute-aligned copies of PredictTakenF
  logic pred_dec_q, pred_dec_d;
  logic pred_exe_q, pred_exe_d;

  logic [IDX_BITS-1:0] idx_f, idx_e;
  logic [TagW-1:0]     tag_f, tag_e;
  logic                hit_f, hit_e;

  assign idx_f = PCF[IDX_BITS+1:2];
  assign tag_f = PCF[31:IDX_BITS+2];
  assign idx_e = PCE[IDX_BITS+1:2];
  assign tag_e = PCE[31:IDX_BITS+2];

  // Lookup reads registered contents, so a same-cycle update is seen next cycle
  always_comb begin
    hit_f          = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    hit_e          = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    PredictTakenF  = hit_f && ctr_q[idx_f][1];
    PredictTargetF = PredictTakenF ? tgt_q[idx_f] : (PCF + 32'd4);
  end

  // Execute-stage outputs; mispredict is masked while in reset
  always_comb begin
    PredictTaken = pred_exe_q;
    if (reset) begin
      Mispredict = 1'b0;
    end else if (BranchE) begin
      Mispredict = (pred_exe_q != BranchTaken);
    end else begin
      Mispredict = pred_exe_q;
    end
  end

  // Next-state for the table: train on hit, allocate on taken miss
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    ctr_d   = ctr_q;
    tgt_d   = tgt_q;
    if (BranchE) begin
      if (hit_e) begin
        if (BranchTaken) begin
          ctr_d[idx_e] = (ctr_q[idx_e] == 2'b11) ? 2'b11 : ctr_q[idx_e] + 2'd1;
          tgt_d[idx_e] = BranchTargetE;
        end else begin
          ctr_d[idx_e] = (ctr_q[idx_e] == 2'b00) ? 2'b00 : ctr_q[idx_e] - 2'd1;
        end
      end else if (BranchTaken) begin
        valid_d[idx_e] = 1'b1;
        tag_d[idx_e]   = tag_e;
        ctr_d[idx_e]   = 2'b10;
        tgt_d[idx_e]   = BranchTargetE;
      end
    end
  end

  // Next-state for the prediction pipeline; flush beats stall in Decode
  always_comb begin
    if (FlushD) begin
      pred_dec_d = 1'b0;
    end else if (StallD) begin
      pred_dec_d = pred_dec_q;
    end else begin
      pred_dec_d = PredictTakenF;
    end
    pred_exe_d = FlushE ? 1'b0 : pred_dec_q;
  end

  // State registers with synchronous reset; targets and tags need no reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      pred_dec_q <= 1'b0;
      pred_exe_q <= 1'b0;
      for (int i = 0; i < Entries; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else begin
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      ctr_q      <= ctr_d;
      tgt_q      <= tgt_d;
      pred_dec_q <= pred_dec_d;
      pred_exe_q <= pred_exe_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor.
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] PCF;
  logic        StallD, FlushD, FlushE;
  logic        BranchE, BranchTaken;
  logic [31:0] PCE, BranchTargetE;
  logic        PredictTakenF;
  logic [31:0] PredictTargetF;
  logic        PredictTaken;
  logic        Mispredict;

  branch_predictor #(.IDX_BITS(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .PCF            (PCF),
    .StallD         (StallD),
    .FlushD         (FlushD),
    .FlushE         (FlushE),
    .BranchE        (BranchE),
    .BranchTaken    (BranchTaken),
    .PCE            (PCE),
    .BranchTargetE  (BranchTargetE),
    .PredictTakenF  (PredictTakenF),
    .PredictTargetF (PredictTargetF),
    .PredictTaken   (PredictTaken),
    .Mispredict     (Mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pcf;
    logic        stall_d, flush_d, flush_e;
    logic        br_e, br_t;
    logic [31:0] pce, bte;
    logic        exp_ptf;
    logic [31:0] exp_tgt;
    logic        exp_pt;
    logic        exp_mis;
  } vec_t;

  localparam int NumVec = 25;
  vec_t vecs[NumVec];

  int n_vec;
  int n_bad;

  function automatic vec_t mk(input logic rst, input logic [31:0] pcf, input logic stall_d,
                              input logic flush_d, input logic flush_e, input logic br_e,
                              input logic br_t, input logic [31:0] pce, input logic [31:0] bte,
                              input logic exp_ptf, input logic [31:0] exp_tgt,
                              input logic exp_pt, input logic exp_mis);
    vec_t v;
    v.rst = rst; v.pcf = pcf; v.stall_d = stall_d; v.flush_d = flush_d; v.flush_e = flush_e;
    v.br_e = br_e; v.br_t = br_t; v.pce = pce; v.bte = bte;
    v.exp_ptf = exp_ptf; v.exp_tgt = exp_tgt; v.exp_pt = exp_pt; v.exp_mis = exp_mis;
    return v;
  endfunction

  // Drive one vector after the falling edge, check outputs 1 time unit later
  task automatic apply(input string name, input vec_t v);
    @(negedge clk);
    reset = v.rst; PCF = v.pcf; StallD = v.stall_d; FlushD = v.flush_d; FlushE = v.flush_e;
    BranchE = v.br_e; BranchTaken = v.br_t; PCE = v.pce; BranchTargetE = v.bte;
    #1;
    n_vec++;
    if (PredictTakenF !== v.exp_ptf || PredictTargetF !== v.exp_tgt ||
        PredictTaken !== v.exp_pt || Mispredict !== v.exp_mis) begin
      n_bad++;
      $display("FAIL %s: got ptf=%b tgt=%h pt=%b mis=%b, want ptf=%b tgt=%h pt=%b mis=%b",
               name, PredictTakenF, PredictTargetF, PredictTaken, Mispredict,
               v.exp_ptf, v.exp_tgt, v.exp_pt, v.exp_mis);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    //              rst pcf       sd fd fe be bt pce       bte          ptf tgt       pt mis
    vecs[0]  = mk(0, 32'h100, 0, 0, 0, 0, 0, 32'h0,   32'h0,   0, 32'h104, 0, 0); // cold miss
    vecs[1]  = mk(0, 32'h100, 0, 0, 0, 1, 1, 32'h100, 32'h200, 0, 32'h104, 0, 1); // allocate
    vecs[2]  = mk(0, 32'h100, 0, 0, 0, 0, 0, 32'h0,   32'h0,   1, 32'h200, 0, 0);
    vecs[3]  = mk(0, 32'h104, 0, 0, 0, 0, 1, 32'h104, 32'h500, 0, 32'h108, 0, 0); // BE=0
    vecs[4]  = mk(0, 32'h104, 0, 0, 0, 0, 0, 32'h0,   32'h0,   0, 32'h108, 1, 1); // n+2
    vecs[5]  = mk(0, 32'h100, 0, 0, 0, 1, 1, 32'h100, 32'h300, 1, 32'h200, 0, 1); // ->11
    vecs[6]  = mk(0, 32'h100, 0, 0, 0, 1, 1, 32'h100, 32'h300, 1, 32'h300, 0, 1); // sat 11
    vecs[7]  = mk(0, 32'h100, 0, 0, 0, 1, 0, 32'h100, 32'h0,   1, 32'h300, 1, 1); // ->10
    vecs[8]  = mk(0, 32'h100, 0, 0, 0, 1, 0, 32'h100, 32'h0,   1, 32'h300, 1, 1); // ->01
    vecs[9]  = mk(0, 32'h100, 0, 0, 0, 1, 0, 32'h100, 32'h0,   0, 32'h104, 1, 1); // ->00
    vecs[10] = mk(0, 32'h100, 0, 0, 0, 1, 0, 32'h100, 32'h0,   0, 32'h104, 1, 1); // sat 00
    vecs[11] = mk(0, 32'h100, 0, 0, 0, 1, 1, 32'h100, 32'h200, 0, 32'h104, 0, 1); // ->01
    vecs[12] = mk(0, 32'h100, 0, 0, 0, 1, 1, 32'h100, 32'h200, 0, 32'h104, 0, 1); // ->10
    vecs[13] = mk(0, 32'h100, 0, 0, 0, 0, 0, 32'h0,   32'h0,   1, 32'h200, 0, 0);
    vecs[14] = mk(0, 32'h140, 0, 0, 0, 1, 0, 32'h140, 32'h0,   0, 32'h144, 0, 0); // alias
    vecs[15] = mk(0, 32'h100, 0, 0, 0, 0, 0, 32'h0,   32'h0,   1, 32'h200, 1, 1);
    vecs[16] = mk(0, 32'h104, 1, 0, 0, 0, 0, 32'h0,   32'h0,   0, 32'h108, 0, 0); // stall
    vecs[17] = mk(0, 32'h104, 1, 0, 0, 0, 0, 32'h0,   32'h0,   0, 32'h108, 1, 1);
    vecs[18] = mk(0, 32'h104, 0, 0, 1, 0, 0, 32'h0,   32'h0,   0, 32'h108, 1, 1); // FlushE
    vecs[19] = mk(0, 32'h104, 0, 0, 0, 0, 0, 32'h0,   32'h0,   0, 32'h108, 0, 0);
    vecs[20] = mk(0, 32'h100, 0, 1, 0, 0, 0, 32'h0,   32'h0,   1, 32'h200, 0, 0); // FlushD
    vecs[21] = mk(0, 32'h100, 0, 0, 0, 0, 0, 32'h0,   32'h0,   1, 32'h200, 0, 0);
    vecs[22] = mk(0, 32'h100, 0, 0, 0, 0, 0, 32'h0,   32'h0,   1, 32'h200, 0, 0);
    vecs[23] = mk(1, 32'h100, 1, 0, 0, 1, 1, 32'h100, 32'h900, 1, 32'h200, 1, 0); // reset
    vecs[24] = mk(0, 32'h100, 0, 0, 0, 0, 0, 32'h0,   32'h0,   0, 32'h104, 0, 0);

    // Initial reset for two edges with all other inputs idle
    reset = 1'b1; PCF = 32'h0; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
    BranchE = 1'b0; BranchTaken = 1'b0; PCE = 32'h0; BranchTargetE = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (Mispredict !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mis: got mis=%b, want 0", Mispredict);
    end

    for (int i = 0; i < NumVec; i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Hand sequence: allocate index 2 after reset, entry 0 must stay invalid,
    // then a second reset taken mid-update leaves nothing behind.
    apply("alloc_idx2", mk(0, 32'h108, 0, 0, 0, 1, 1, 32'h108, 32'h400, 0, 32'h10c, 0, 1));
    apply("hit_idx2",   mk(0, 32'h108, 0, 0, 0, 0, 0, 32'h0,   32'h0,   1, 32'h400, 0, 0));
    apply("idx0_clean", mk(0, 32'h100, 0, 0, 0, 0, 0, 32'h0,   32'h0,   0, 32'h104, 0, 0));
    apply("pipe_idx2",  mk(1, 32'h108, 0, 1, 1, 1, 1, 32'h108, 32'h800, 1, 32'h400, 1, 0));
    apply("post_rst",   mk(0, 32'h108, 0, 0, 0, 0, 0, 32'h0,   32'h0,   0, 32'h10c, 0, 0));
    apply("post_rst2",  mk(0, 32'h108, 0, 0, 0, 0, 0, 32'h0,   32'h0,   0, 32'h10c, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
